// File: rtl/alu_op_sequencer_if.sv
// Signal bundle between the operate-instruction sequencer and its neighbours:
// instruction source, register file read/write ports and the combinational ALU.
interface alu_op_sequencer_if;
    // Handshake: an instruction transfers on a rising edge where IR_valid and
    // IR_ready are both high; IR_ready depends only on sequencer state, never on IR_valid.
    logic [15:0] IR_in;
    logic        IR_valid;
    logic        IR_ready;

    logic [2:0]  SR1_addr;
    logic [2:0]  SR2_addr;
    logic [15:0] SR1_data;
    logic [15:0] SR2_data;

    logic [15:0] ALU_A;
    logic [15:0] ALU_B;
    logic [1:0]  ALUK;
    logic [15:0] ALU_out;

    logic        DR_we;
    logic [2:0]  DR_addr;
    logic [15:0] DR_data;
    logic [2:0]  NZP;
    logic        ILL;

    // Datapath side: supplies instructions, register reads and ALU results.
    modport master (
        output IR_in, IR_valid, SR1_data, SR2_data, ALU_out,
        input  IR_ready, SR1_addr, SR2_addr, ALU_A, ALU_B, ALUK,
        input  DR_we, DR_addr, DR_data, NZP, ILL
    );

    // Sequencer side.
    modport slave (
        input  IR_in, IR_valid, SR1_data, SR2_data, ALU_out,
        output IR_ready, SR1_addr, SR2_addr, ALU_A, ALU_B, ALUK,
        output DR_we, DR_addr, DR_data, NZP, ILL
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Four-state issue/retire sequencer for LC-3b ADD, AND and XOR/NOT: decode and
// operand fetch, ALU drive, result capture, register writeback and NZP update.
module alu_op_sequencer (
    input  logic                CLK,
    input  logic                RESET,
    alu_op_sequencer_if.slave   bus,
    output logic [1:0]          dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DECODE    = 2'd1,
        S_EXECUTE   = 2'd2,
        S_WRITEBACK = 2'd3
    } state_e;

    localparam logic [3:0] OP_ADD     = 4'b0001;
    localparam logic [3:0] OP_AND     = 4'b0101;
    localparam logic [3:0] OP_XOR     = 4'b1001;
    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_XOR   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;
    localparam logic [2:0] NZP_ZERO   = 3'b010;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    logic [15:0] result_q, result_d;
    logic [2:0]  nzp_q, nzp_d;

    logic        op_legal;
    logic [1:0]  op_aluk;
    logic [15:0] imm16;
    logic [2:0]  wb_nzp;

    // Opcode decode from the latched instruction only, so IR_in may change freely while busy.
    always_comb begin
        op_legal = 1'b1;
        op_aluk  = ALUK_PASSA;
        case (ir_q[15:12])
            OP_ADD:  op_aluk = ALUK_ADD;
            OP_AND:  op_aluk = ALUK_AND;
            OP_XOR:  op_aluk = ALUK_XOR;
            default: op_legal = 1'b0;
        endcase
    end

    assign imm16 = {{11{ir_q[4]}}, ir_q[4:0]};

    // Exactly one condition-code bit is set for any result value.
    assign wb_nzp = {result_q[15], (result_q == 16'h0000), (~result_q[15] & (result_q != 16'h0000))};

    assign bus.SR1_addr = ir_q[8:6];
    assign bus.SR2_addr = ir_q[2:0];
    assign bus.NZP      = nzp_q;
    assign dbg_state_o  = state_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            ir_q     <= 16'h0000;
            op_a_q   <= 16'h0000;
            op_b_q   <= 16'h0000;
            result_q <= 16'h0000;
            nzp_q    <= NZP_ZERO;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            nzp_q    <= nzp_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        result_d     = result_q;
        nzp_d        = nzp_q;
        bus.IR_ready = 1'b0;
        bus.ALU_A    = 16'h0000;
        bus.ALU_B    = 16'h0000;
        bus.ALUK     = ALUK_PASSA;
        bus.DR_we    = 1'b0;
        bus.DR_addr  = 3'b000;
        bus.DR_data  = 16'h0000;
        bus.ILL      = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.IR_ready = 1'b1;
                if (bus.IR_valid) begin
                    ir_d    = bus.IR_in;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                op_a_d = bus.SR1_data;
                op_b_d = ir_q[5] ? imm16 : bus.SR2_data;
                if (op_legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    bus.ILL = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_EXECUTE: begin
                bus.ALU_A = op_a_q;
                bus.ALU_B = op_b_q;
                bus.ALUK  = op_aluk;
                result_d  = bus.ALU_out;
                state_d   = S_WRITEBACK;
            end

            S_WRITEBACK: begin
                bus.DR_we   = 1'b1;
                bus.DR_addr = ir_q[11:9];
                bus.DR_data = result_q;
                nzp_d       = wb_nzp;
                state_d     = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Structural invariants of the retire side.
    a_we_ill_exclusive: assert property (@(posedge CLK) disable iff (RESET) !(bus.DR_we && bus.ILL));
    a_nzp_onehot:       assert property (@(posedge CLK) disable iff (RESET) $onehot(nzp_q));
    a_we_single_pulse:  assert property (@(posedge CLK) disable iff (RESET) bus.DR_we |=> !bus.DR_we);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: register file and ALU models around the DUT,
// cycle-exact checks per instruction plus a writeback scoreboard.
module tb_alu_op_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [1:0] dbg_state;

    alu_op_sequencer_if bus();

    alu_op_sequencer dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [18:0] exp_q[$];
    logic [15:0] ref_rf [8];
    logic [2:0]  exp_nzp = 3'b010;

    // Register file: combinational read, write at the rising edge.
    logic [15:0] rf [8];
    logic        pre_we = 1'b0;
    logic [2:0]  pre_addr = 3'd0;
    logic [15:0] pre_data = 16'h0;

    assign bus.SR1_data = rf[bus.SR1_addr];
    assign bus.SR2_data = rf[bus.SR2_addr];

    always @(posedge CLK) begin
        if (!RESET && bus.DR_we) rf[bus.DR_addr] <= bus.DR_data;
        else if (pre_we)         rf[pre_addr]    <= pre_data;
    end

    always_comb begin
        case (bus.ALUK)
            2'b00:   bus.ALU_out = bus.ALU_A + bus.ALU_B;
            2'b01:   bus.ALU_out = bus.ALU_A & bus.ALU_B;
            2'b10:   bus.ALU_out = bus.ALU_A ^ bus.ALU_B;
            default: bus.ALU_out = bus.ALU_A;
        endcase
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Writeback monitor: every DR_we pulse must match the oldest predicted result.
    always @(negedge CLK) begin
        if (!RESET && bus.DR_we) begin
            logic [18:0] e;
            check("we_ill_excl", {15'b0, bus.ILL}, 16'h0);
            check("wb_pending", 16'(exp_q.size()), 16'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wb_addr", {13'b0, bus.DR_addr}, {13'b0, e[18:16]});
                check("wb_data", bus.DR_data, e[15:0]);
            end
        end
    end

    task automatic set_reg(input logic [2:0] a, input logic [15:0] v);
        pre_addr = a;
        pre_data = v;
        pre_we   = 1'b1;
        ref_rf[a] = v;
        @(posedge CLK);
        #1 pre_we = 1'b0;
        @(negedge CLK);
    endtask

    function automatic void predict(input logic [15:0] ir, output logic legal, output logic [1:0] k,
                                    output logic [15:0] a, output logic [15:0] b, output logic [15:0] r);
        a = ref_rf[ir[8:6]];
        b = ir[5] ? {{11{ir[4]}}, ir[4:0]} : ref_rf[ir[2:0]];
        legal = 1'b1;
        case (ir[15:12])
            4'h1:    begin k = 2'b00; r = a + b; end
            4'h5:    begin k = 2'b01; r = a & b; end
            4'h9:    begin k = 2'b10; r = a ^ b; end
            default: begin k = 2'b11; r = 16'h0; legal = 1'b0; end
        endcase
    endfunction

    // Called at a negedge while the DUT is idle; returns at the negedge of the
    // first cycle the DUT is idle again.
    task automatic run_op(input logic [15:0] ir, input bit hold);
        logic        legal;
        logic [1:0]  k;
        logic [15:0] a, b, r;
        logic [2:0]  nzp_before;
        predict(ir, legal, k, a, b, r);
        nzp_before = exp_nzp;
        bus.IR_in    = ir;
        bus.IR_valid = 1'b1;
        check("ready_idle", {15'b0, bus.IR_ready}, 16'h1);
        if (legal) begin
            exp_q.push_back({ir[11:9], r});
            ref_rf[ir[11:9]] = r;
            exp_nzp = {r[15], (r == 16'h0), (!r[15] && r != 16'h0)};
        end
        @(posedge CLK);
        @(negedge CLK);
        if (!hold) bus.IR_valid = 1'b0;
        bus.IR_in = 16'($urandom);
        check("c1_ready", {15'b0, bus.IR_ready}, 16'h0);
        check("c1_ill", {15'b0, bus.ILL}, {15'b0, !legal});
        check("c1_sr1", {13'b0, bus.SR1_addr}, {13'b0, ir[8:6]});
        check("c1_sr2", {13'b0, bus.SR2_addr}, {13'b0, ir[2:0]});
        check("c1_aluk", {14'b0, bus.ALUK}, 16'h3);
        @(negedge CLK);
        if (!legal) begin
            check("ill_c2_ready", {15'b0, bus.IR_ready}, 16'h1);
            check("ill_c2_ill", {15'b0, bus.ILL}, 16'h0);
            check("ill_nzp", {13'b0, bus.NZP}, {13'b0, nzp_before});
            return;
        end
        check("c2_ready", {15'b0, bus.IR_ready}, 16'h0);
        check("c2_aluk", {14'b0, bus.ALUK}, {14'b0, k});
        check("c2_alu_a", bus.ALU_A, a);
        check("c2_alu_b", bus.ALU_B, b);
        @(negedge CLK);
        check("c3_ready", {15'b0, bus.IR_ready}, 16'h0);
        check("c3_we", {15'b0, bus.DR_we}, 16'h1);
        check("c3_aluk", {14'b0, bus.ALUK}, 16'h3);
        @(negedge CLK);
        check("c4_ready", {15'b0, bus.IR_ready}, 16'h1);
        check("c4_we", {15'b0, bus.DR_we}, 16'h0);
        check("c4_nzp", {13'b0, bus.NZP}, {13'b0, exp_nzp});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_nzp"}, {13'b0, bus.NZP}, 16'h2);
        check({tag, "_we"}, {15'b0, bus.DR_we}, 16'h0);
        check({tag, "_ill"}, {15'b0, bus.ILL}, 16'h0);
        check({tag, "_aluk"}, {14'b0, bus.ALUK}, 16'h3);
        check({tag, "_ready"}, {15'b0, bus.IR_ready}, 16'h1);
        check({tag, "_alu_a"}, bus.ALU_A, 16'h0);
        check({tag, "_alu_b"}, bus.ALU_B, 16'h0);
        check({tag, "_dr_addr"}, {13'b0, bus.DR_addr}, 16'h0);
        check({tag, "_dr_data"}, bus.DR_data, 16'h0);
        check({tag, "_state"}, {14'b0, dbg_state}, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  legal_tbl [3];
        logic [15:0] ir;
        legal_tbl[0] = 4'h1;
        legal_tbl[1] = 4'h5;
        legal_tbl[2] = 4'h9;
        bus.IR_in    = 16'h0;
        bus.IR_valid = 1'b0;

        // Reset state
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        check_reset_values("rst");
        RESET = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 8; i++) set_reg(3'(i), 16'($urandom));

        // ADD register mode: R3 = 5 + 3
        set_reg(3'd1, 16'h0005);
        set_reg(3'd2, 16'h0003);
        run_op(16'h1642, 1'b0);

        // NOT via XOR imm 11111, then AND with #0
        set_reg(3'd1, 16'h00F0);
        run_op(16'h967F, 1'b0);
        run_op(16'h5660, 1'b0);

        // Back-to-back dependent ADD R1,R1,#-1 with IR_valid held high
        set_reg(3'd1, 16'h0001);
        run_op(16'h127F, 1'b1);
        run_op(16'h127F, 1'b0);

        // Illegal opcode
        run_op(16'hF025, 1'b0);

        // Reset asserted during EXECUTE of an ADD
        set_reg(3'd1, 16'h0005);
        set_reg(3'd2, 16'h0007);
        bus.IR_in    = 16'h1642;
        bus.IR_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.IR_valid = 1'b0;
        @(negedge CLK);
        check("mid_state_exec", {14'b0, dbg_state}, 16'h2);
        RESET = 1'b1;
        #1;
        check_reset_values("mid_rst");
        exp_nzp = 3'b010;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        run_op(16'h1642, 1'b0);

        // Random mix of legal and illegal instructions
        for (int i = 0; i < 24; i++) begin
            ir = 16'($urandom);
            if ($urandom_range(0, 3) != 0) ir[15:12] = legal_tbl[$urandom_range(0, 2)];
            run_op(ir, (i != 23) && ($urandom_range(0, 1) == 1));
        end
        bus.IR_valid = 1'b0;
        repeat (3) @(negedge CLK);
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
